// File: rtl/fft_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_avg_pkg
// Description : Shared types and constants for the FFT bin-averaging sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_avg_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARM      = 2'd1,
        S_RUN      = 2'd2,
        S_STOPPING = 2'd3
    } state_t;

    // Default build geometry; parameterised instances derive their own widths.
    localparam int DEF_BEATS_PER_FRAME = 256;
    localparam int DEF_MAX_LOG2_AVG    = 10;
    localparam int BEAT_W              = $clog2(DEF_BEATS_PER_FRAME);
    localparam int FRAME_W             = DEF_MAX_LOG2_AVG;

    function automatic logic [3:0] clamp_shift(input logic [3:0] k, input logic [3:0] k_max);
        return (k > k_max) ? k_max : k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_avg_sequencer_counter.sv
`default_nettype none
// ============================================================================
// Module      : frame_beat_counter
// Description : Cascaded beat/frame counter with programmable frame wrap 2^k-1.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_beat_counter #(
    parameter int BEATS_PER_FRAME = 256,
    parameter int FRAME_W         = 10
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic                               clr,
    input  logic                               restart,
    input  logic [3:0]                         shift,
    output logic [$clog2(BEATS_PER_FRAME)-1:0] beat,
    output logic [FRAME_W-1:0]                 frame,
    output logic                               beat_tc,
    output logic                               frame_tc
);
    localparam int c_beat_w = $clog2(BEATS_PER_FRAME);

    logic [c_beat_w-1:0] r_beat;
    logic [FRAME_W-1:0]  r_frame;
    logic [FRAME_W-1:0]  w_frame_term;

    // 2^shift-1 as a mask; shift==FRAME_W gives all ones
    assign w_frame_term = ~({FRAME_W{1'b1}} << shift);
    assign beat_tc      = (r_beat == c_beat_w'(BEATS_PER_FRAME - 1));
    assign frame_tc     = (r_frame == w_frame_term);
    assign beat         = r_beat;
    assign frame        = r_frame;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_beat  <= '0;
            r_frame <= '0;
        end else if (en) begin
            if (restart) begin
                // the restarting beat itself is beat 0, so continue from beat 1
                r_beat  <= c_beat_w'(1);
                r_frame <= '0;
            end else begin
                r_beat <= r_beat + c_beat_w'(1);
                if (beat_tc) begin
                    r_frame <= frame_tc ? '0 : r_frame + FRAME_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_avg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fft_avg_sequencer
// Description : Period/frame sequencer driving the FFT bin-averaging strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_avg_sequencer
    import fft_avg_pkg::*;
#(
    parameter int BEATS_PER_FRAME = 256,
    parameter int MAX_LOG2_AVG    = 10,
    parameter int DUMP_CNT_W      = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [3:0]                         cfg_log2_avg,
    input  logic                               cfg_start,
    input  logic                               cfg_stop,
    input  logic                               fft_valid,
    input  logic                               fft_sof,
    output logic                               avg_en,
    output logic                               avg_first,
    output logic                               avg_last,
    output logic                               avg_dump,
    output logic [3:0]                         avg_shift,
    output logic [$clog2(BEATS_PER_FRAME)-1:0] bin_idx,
    output logic                               busy,
    output logic                               sync_err,
    output logic [DUMP_CNT_W-1:0]              dump_count
);
    localparam int c_beat_w  = $clog2(BEATS_PER_FRAME);
    localparam int c_frame_w = MAX_LOG2_AVG;

    state_t r_state;
    state_t w_next;

    logic [3:0]            r_shift;
    logic                  r_en, r_first, r_last, r_dump, r_busy, r_serr;
    logic [c_beat_w-1:0]   r_bin;
    logic [DUMP_CNT_W-1:0] r_dcnt;

    logic [c_beat_w-1:0]   w_beat;
    logic [c_frame_w-1:0]  w_frame;
    logic                  w_beat_tc, w_frame_tc;
    logic                  w_active, w_take, w_sync, w_start;
    logic                  w_first, w_last, w_dump;
    logic [c_beat_w-1:0]   w_eff_beat;

    frame_beat_counter #(
        .BEATS_PER_FRAME (BEATS_PER_FRAME),
        .FRAME_W         (c_frame_w)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (w_take),
        .clr      (r_state == S_IDLE),
        .restart  (w_sync),
        .shift    (r_shift),
        .beat     (w_beat),
        .frame    (w_frame),
        .beat_tc  (w_beat_tc),
        .frame_tc (w_frame_tc)
    );

    assign w_active = (r_state == S_RUN) || (r_state == S_STOPPING);
    assign w_start  = (r_state == S_IDLE) && cfg_start && !cfg_stop;
    // an SOF off the frame boundary re-anchors the period at frame 0, beat 0
    assign w_sync   = w_active && fft_valid && fft_sof && (w_beat != '0);
    assign w_take   = (w_active && fft_valid) ||
                      ((r_state == S_ARM) && fft_valid && fft_sof && !cfg_stop);

    assign w_eff_beat = w_sync ? '0 : w_beat;
    assign w_first    = w_take && (w_sync || (w_frame == '0));
    assign w_last     = w_take && (w_sync ? (r_shift == 4'd0) : w_frame_tc);
    assign w_dump     = w_last && !w_sync && w_beat_tc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_ARM;
            end
            S_ARM: begin
                if (cfg_stop)                    w_next = S_IDLE;
                else if (fft_valid && fft_sof)   w_next = S_RUN;
            end
            S_RUN: begin
                if (cfg_stop) w_next = w_dump ? S_IDLE : S_STOPPING;
            end
            S_STOPPING: begin
                if (w_dump) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en    <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_dump  <= 1'b0;
            r_bin   <= '0;
            r_busy  <= 1'b0;
            r_shift <= 4'd0;
            r_serr  <= 1'b0;
            r_dcnt  <= '0;
        end else begin
            r_en    <= w_take;
            r_first <= w_first;
            r_last  <= w_last;
            r_dump  <= w_dump;
            r_bin   <= w_take ? w_eff_beat : '0;
            r_busy  <= (w_next != S_IDLE);
            if (w_start) begin
                r_shift <= clamp_shift(cfg_log2_avg, 4'(MAX_LOG2_AVG));
                r_serr  <= 1'b0;
                r_dcnt  <= '0;
            end else begin
                if (w_sync) r_serr <= 1'b1;
                if (w_dump) r_dcnt <= r_dcnt + DUMP_CNT_W'(1);
            end
        end
    end

    assign avg_en     = r_en;
    assign avg_first  = r_first;
    assign avg_last   = r_last;
    assign avg_dump   = r_dump;
    assign avg_shift  = r_shift;
    assign bin_idx    = r_bin;
    assign busy       = r_busy;
    assign sync_err   = r_serr;
    assign dump_count = r_dcnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_avg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_avg_sequencer
// Description : Scoreboard bench for fft_avg_sequencer (8 beats/frame, k max 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_avg_sequencer;
    localparam int BPF  = 8;
    localparam int MAXL = 4;

    logic        clk, rst_n;
    logic [3:0]  cfg_log2_avg;
    logic        cfg_start, cfg_stop, fft_valid, fft_sof;
    logic        avg_en, avg_first, avg_last, avg_dump, busy, sync_err;
    logic [3:0]  avg_shift;
    logic [2:0]  bin_idx;
    logic [15:0] dump_count;

    fft_avg_sequencer #(.BEATS_PER_FRAME(BPF), .MAX_LOG2_AVG(MAXL), .DUMP_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_log2_avg(cfg_log2_avg), .cfg_start(cfg_start),
        .cfg_stop(cfg_stop), .fft_valid(fft_valid), .fft_sof(fft_sof), .avg_en(avg_en),
        .avg_first(avg_first), .avg_last(avg_last), .avg_dump(avg_dump), .avg_shift(avg_shift),
        .bin_idx(bin_idx), .busy(busy), .sync_err(sync_err), .dump_count(dump_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_on   = 1'b0;
    // {first,last,dump,serr,shift[3:0],bin[2:0],dcnt[15:0]}
    logic [26:0] q[$];

    int g_k, g_n, g_dc;
    bit g_serr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (avg_en === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 64'(avg_en), 64'(0));
                end else begin
                    check("beat_strobes",
                          64'({avg_first, avg_last, avg_dump, sync_err, avg_shift, bin_idx, dump_count}),
                          64'(q.pop_front()));
                end
            end else begin
                check("gap_strobes", 64'({avg_en, avg_first, avg_last, avg_dump}), 64'(0));
            end
        end
    end

    task automatic drive(input bit v, input bit sof, input bit start, input bit stop);
        fft_valid = v; fft_sof = sof; cfg_start = start; cfg_stop = stop;
        @(posedge clk); #1;
        fft_valid = 0; fft_sof = 0; cfg_start = 0; cfg_stop = 0;
    endtask

    task automatic gap();
        drive(0, 0, 0, 0);
    endtask

    // Expected strobes from the flat beat index within the period.
    task automatic vbeat(input bit sof, input bit start, input bit stop);
        int per;
        logic [26:0] e;
        bit f, l, d;
        per = BPF << g_k;
        if (sof && (g_n % BPF) != 0) begin
            g_serr = 1'b1;
            g_n    = 0;
        end
        f = (g_n < BPF);
        l = (g_n >= per - BPF);
        d = (g_n == per - 1);
        if (d) g_dc++;
        e = {f, l, d, g_serr, 4'(g_k), 3'(g_n % BPF), 16'(g_dc)};
        q.push_back(e);
        g_n = (g_n + 1) % per;
        drive(1, sof, start, stop);
    endtask

    task automatic do_start(input int k);
        cfg_log2_avg = 4'(k);
        drive(0, 0, 1, 0);
        g_k = (k > MAXL) ? MAXL : k; g_n = 0; g_dc = 0; g_serr = 1'b0;
        check("start_busy", 64'(busy), 64'(1));
        check("start_shift", 64'(avg_shift), 64'(g_k));
        check("start_clear", 64'({sync_err, dump_count}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 0; cfg_log2_avg = 0; cfg_start = 0; cfg_stop = 0; fft_valid = 0; fft_sof = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({avg_en, avg_first, avg_last, avg_dump, avg_shift, bin_idx,
                                    busy, sync_err, dump_count}), 64'(0));
        rst_n = 1;
        mon_on = 1'b1;
        gap();

        // Normal k=2 period, stop on the final beat
        do_start(2);
        for (int i = 0; i < 32; i++) vbeat(i % 8 == 0, 0, i == 31);
        check("normal_dcnt", 64'(dump_count), 64'(1));
        check("normal_idle", 64'(busy), 64'(0));
        gap();

        // k=0: dump every frame
        do_start(0);
        for (int i = 0; i < 24; i++) vbeat(i % 8 == 0, 0, i == 23);
        check("k0_dcnt", 64'(dump_count), 64'(3));
        check("k0_idle", 64'(busy), 64'(0));
        gap();

        // Throttled k=1: valid on alternate cycles
        do_start(1);
        for (int i = 0; i < 16; i++) begin
            vbeat(i == 0, 0, i == 15);
            if (i < 15) gap();
        end
        check("throttle_dcnt", 64'(dump_count), 64'(1));
        gap();

        // Sync error at frame 1 beat 5 (beat 13 of the period)
        do_start(1);
        for (int i = 0; i < 13; i++) vbeat(i % 8 == 0, 0, 0);
        check("presync_err", 64'(sync_err), 64'(0));
        vbeat(1, 0, 0);
        check("sync_err_set", 64'(sync_err), 64'(1));
        for (int i = 0; i < 14; i++) vbeat(0, 0, 0);
        check("sync_dcnt_hold", 64'(dump_count), 64'(0));
        vbeat(0, 0, 0);
        check("sync_dump", 64'({sync_err, avg_dump, dump_count}), 64'({1'b1, 1'b1, 16'd1}));

        // Stop at beat 10 of the next period
        for (int i = 0; i < 10; i++) vbeat(i % 8 == 0, 0, 0);
        vbeat(0, 0, 1);
        check("stopping_busy", 64'(busy), 64'(1));
        for (int i = 11; i < 16; i++) vbeat(0, 0, i == 12);
        check("stop_done", 64'({busy, dump_count}), 64'({1'b0, 16'd2}));
        gap();

        // Stop in ARM (stop wins over a coincident SOF)
        do_start(2);
        drive(1, 1, 0, 1);
        check("arm_stop", 64'({busy, avg_en}), 64'(0));
        gap();

        // Start and stop together stays idle
        drive(0, 0, 1, 1);
        check("start_stop_idle", 64'(busy), 64'(0));

        // Clamp k=9 to 4; k change and restart while busy are ignored
        do_start(9);
        for (int i = 0; i < 128; i++) begin
            if (i == 64) cfg_log2_avg = 4'd0;
            vbeat(i % 8 == 0, 0, 0);
        end
        check("clamp_dcnt", 64'({avg_shift, dump_count}), 64'({4'd4, 16'd1}));
        for (int i = 0; i < 5; i++) vbeat(i == 0, i == 3, 0);
        check("busy_start_ignored", 64'({busy, dump_count}), 64'({1'b1, 16'd1}));

        // Reset mid-period
        rst_n = 0;
        @(posedge clk); #1;
        check("midreset_outputs", 64'({avg_en, avg_first, avg_last, avg_dump, avg_shift, bin_idx,
                                       busy, sync_err, dump_count}), 64'(0));
        rst_n = 1;
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0);
        check("post_reset_idle", 64'({busy, avg_en}), 64'(0));
        gap();
        gap();
        check("scoreboard_drained", 64'(q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
